// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: loads the round-10 key byte-serially and streams round keys 10..0.
// Build option: define AES_INV_KS_SBOX_REG_EN to register the S-box output (STEP takes 5 cycles instead of 4).
module aes_inv_key_schedule (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       key_in_valid,
  output logic       key_in_ready,
  output logic [7:0] key_out,
  output logic       key_out_valid,
  input  logic       key_out_ready,
  output logic [3:0] key_out_round,
  output logic       key_out_last,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, STEP, DONE} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef AES_INV_KS_SBOX_REG_EN
  localparam logic [2:0] STEP_LAST = 3'd4;
`else
  localparam logic [2:0] STEP_LAST = 3'd3;
`endif

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    logic [10:0] base;
    base = 11'd2047 - {b, 3'b000};
    return SBOX[base -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
  endfunction

  function automatic logic [31:0] rcon_word(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   round_q, round_d;
  logic [2:0]   step_q, step_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_out;
  logic [31:0] w0_mix;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Single shared 4-byte S-box, fed with RotWord(w3) (w3 already holds its new value by then).
  assign sub_out = sub_word({w3[23:0], w3[31:24]});

`ifdef AES_INV_KS_SBOX_REG_EN
  logic [31:0] sbox_q, sbox_d;

  always_comb begin
    sbox_d = sub_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sbox_q <= 32'h0;
    else      sbox_q <= sbox_d;
  end

  assign w0_mix = sbox_q;
`else
  assign w0_mix = sub_out;
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    round_d = round_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (key_in_valid) begin
          key_d   = {key_q[119:0], key_in};
          idx_d   = 4'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (key_in_valid) begin
          key_d = {key_q[119:0], key_in};
          if (idx_q == 4'd15) begin
            idx_d   = 4'd0;
            round_d = 4'd10;
            state_d = EMIT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      EMIT: begin
        if (key_out_ready) begin
          if (idx_q == 4'd15) begin
            idx_d  = 4'd0;
            step_d = 3'd0;
            state_d = (round_q == 4'd0) ? DONE : STEP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      STEP: begin
        case (step_q)
          3'd0:    key_d[31:0]  = w3 ^ w2;
          3'd1:    key_d[63:32] = w2 ^ w1;
          3'd2:    key_d[95:64] = w1 ^ w0;
          default: ;
        endcase
        if (step_q == STEP_LAST) begin
          key_d[127:96] = w0 ^ w0_mix ^ rcon_word(round_q);
          round_d       = round_q - 4'd1;
          step_d        = 3'd0;
          state_d       = EMIT;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      key_q   <= 128'h0;
      idx_q   <= 4'd0;
      round_q <= 4'd0;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      step_q  <= step_d;
    end
  end

  assign key_in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign key_out_valid = (state_q == EMIT);
  assign key_out       = key_out_valid ? key_q[7'd127 - {idx_q, 3'b000} -: 8] : 8'h00;
  assign key_out_round = round_q;
  assign key_out_last  = key_out_valid && (round_q == 4'd0) && (idx_q == 4'd15);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: vector table plus randomized keys checked against a forward key-expansion model.
module tb_aes_inv_key_schedule;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_in;
  logic       key_in_valid;
  logic       key_in_ready;
  logic [7:0] key_out;
  logic       key_out_valid;
  logic       key_out_ready;
  logic [3:0] key_out_round;
  logic       key_out_last;
  logic       busy;

  aes_inv_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_in_valid (key_in_valid),
    .key_in_ready (key_in_ready),
    .key_out      (key_out),
    .key_out_valid(key_out_valid),
    .key_out_ready(key_out_ready),
    .key_out_round(key_out_round),
    .key_out_last (key_out_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

`ifdef AES_INV_KS_SBOX_REG_EN
  localparam int EXP_SPAN = 226;
`else
  localparam int EXP_SPAN = 216;
`endif

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];

  typedef struct {
    logic [127:0] k0;
    logic [127:0] k10;
    int           mode;
    bit           junk;
    bit           gaps;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // GF(2^8) model of the S-box: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward FIPS-197 expansion from the round-0 key; fills exp_rk[0..10].
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Starts and ends at a falling edge.
  task automatic load_key(input logic [127:0] k, input int nbytes, input bit gaps);
    for (int i = 0; i < nbytes; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        key_in_valid = 1'b0;
        key_in = 8'($urandom);
        @(negedge clk);
      end
      check("load_ready", 128'(key_in_ready), 128'(1'b1));
      key_in = k[127 - 8*i -: 8];
      key_in_valid = 1'b1;
      @(negedge clk);
    end
    key_in_valid = 1'b0;
  endtask

  task automatic run_key(input logic [127:0] k10, input int mode, input bit junk, input bit gaps);
    int cyc, first_cyc, last_cyc, nbytes, exp_round;
    bit done, seen, prev_stall;
    logic [7:0]   prev_byte;
    logic [3:0]   prev_round;
    logic [127:0] acc;
    key_out_ready = 1'b1;
    load_key(k10, 16, gaps);
    check("first_valid", 128'(key_out_valid), 128'(1'b1));
    cyc = 0; first_cyc = 0; last_cyc = 0; nbytes = 0; exp_round = 10;
    done = 0; seen = 0; prev_stall = 0; prev_byte = 8'h00; prev_round = 4'd0; acc = '0;
    while (!done && cyc < 3000) begin
      if (junk) begin
        key_in_valid = 1'b1;
        key_in = 8'hff;
        check("busy_in_ready", 128'(key_in_ready), 128'(1'b0));
      end
      if (key_out_valid) begin
        if (!seen) begin
          seen = 1;
          first_cyc = cyc;
        end
        if (prev_stall) begin
          check("stall_byte", 128'(key_out), 128'(prev_byte));
          check("stall_round", 128'(key_out_round), 128'(prev_round));
        end
        case (mode)
          1:       key_out_ready = (exp_round == 9) ? ~key_out_ready : 1'b1;
          2:       key_out_ready = ($urandom_range(0, 3) != 0);
          default: key_out_ready = 1'b1;
        endcase
        if (key_out_ready) begin
          check("out_round", 128'(key_out_round), 128'(exp_round));
          check("out_last", 128'(key_out_last), 128'(exp_round == 0 && nbytes == 15));
          acc = {acc[119:0], key_out};
          nbytes++;
          prev_stall = 0;
          if (nbytes == 16) begin
            got_rk[exp_round] = acc;
            check($sformatf("round_key_%0d", exp_round), acc, exp_rk[exp_round]);
            nbytes = 0;
            if (exp_round == 0) begin
              done = 1;
              last_cyc = cyc;
            end else begin
              exp_round--;
            end
          end
        end else begin
          prev_stall = 1;
          prev_byte  = key_out;
          prev_round = key_out_round;
        end
      end else begin
        prev_stall = 0;
      end
      @(negedge clk);
      cyc++;
    end
    check("emit_complete", 128'(done), 128'(1'b1));
    if (mode == 0 && done) check("span_cycles", 128'(last_cyc - first_cyc + 1), 128'(EXP_SPAN));
    key_in_valid = 1'b0;
    check("done_busy", 128'(busy), 128'(1'b1));
    check("done_valid", 128'(key_out_valid), 128'(1'b0));
    check("done_in_ready", 128'(key_in_ready), 128'(1'b0));
    @(negedge clk);
    check("idle_busy", 128'(busy), 128'(1'b0));
    check("idle_in_ready", 128'(key_in_ready), 128'(1'b1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 128'(key_in_ready), 128'(1'b1));
    check({tag, "_valid"}, 128'(key_out_valid), 128'(1'b0));
    check({tag, "_key_out"}, 128'(key_out), 128'(8'h00));
    check({tag, "_round"}, 128'(key_out_round), 128'(4'd0));
    check({tag, "_last"}, 128'(key_out_last), 128'(1'b0));
    check({tag, "_busy"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    int  guard;
    bit  found;
    rst = 1'b0;
    key_in = 8'h00;
    key_in_valid = 1'b0;
    key_out_ready = 1'b1;
    build_sbox();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    vecs[0] = '{k0: FIPS_K0, k10: FIPS_K10, mode: 0, junk: 1'b0, gaps: 1'b0};
    vecs[1] = '{k0: FIPS_K0, k10: FIPS_K10, mode: 1, junk: 1'b0, gaps: 1'b0};
    vecs[2] = '{k0: FIPS_K0, k10: FIPS_K10, mode: 0, junk: 1'b1, gaps: 1'b0};
    for (int i = 3; i < 7; i++) begin
      vecs[i].k0 = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      expand(vecs[i].k0);
      vecs[i].k10  = exp_rk[10];
      vecs[i].mode = i % 3;
      vecs[i].junk = 1'($urandom_range(0, 1));
      vecs[i].gaps = 1'b1;
    end

    for (int v = 0; v < 7; v++) begin
      expand(vecs[v].k0);
      run_key(vecs[v].k10, vecs[v].mode, vecs[v].junk, vecs[v].gaps);
      if (vecs[v].k0 == FIPS_K0) begin
        check("fips_round10", got_rk[10], FIPS_K10);
        check("fips_round9", got_rk[9], FIPS_K9);
        check("fips_round0", got_rk[0], FIPS_K0);
      end
    end

    // Reset during STEP of round 5, then a clean reload.
    expand(FIPS_K0);
    key_out_ready = 1'b1;
    load_key(FIPS_K10, 16, 1'b0);
    found = 0;
    guard = 0;
    while (!found && guard < 500) begin
      if (busy && !key_out_valid && key_out_round == 4'd5) found = 1;
      else begin
        @(negedge clk);
        guard++;
      end
    end
    check("step5_reached", 128'(found), 128'(1'b1));
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst_step");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_key(FIPS_K10, 0, 1'b0, 1'b0);

    // Reset partway through a load, then a full load from byte 0.
    load_key({32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)}, 7, 1'b0);
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst_load");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_key(FIPS_K10, 2, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
